red_pitaya_fads_ctrl: RTL

Droplet sort sequencer for the FADS datapath. Qualifies fluorescence events on ADC channel A by threshold, width and peak. For a sort-qualified droplet it waits a programmable flight delay, then drives a fixed-length sort trigger to the ASG, followed by a dead time. Sits between the ADC input and the ASG trigger input. All configuration comes from the housekeeping register bank.

---
 rtl/red_pitaya_fads_pkg.sv | 8 +
 rtl/red_pitaya_fads_ctrl_if.sv | 23 ++
 rtl/red_pitaya_fads_meas.sv | 32 +++
 rtl/red_pitaya_fads_ctrl.sv | 98 +++++++++
 4 files changed

// File: rtl/red_pitaya_fads_pkg.sv
// red_pitaya_fads_pkg: sequencer state encoding and default datapath widths.
package red_pitaya_fads_pkg;
   localparam int FADS_DW = 14;
   localparam int FADS_WW = 16;
   localparam int FADS_TW = 24;
   localparam int FADS_CW = 32;
   typedef enum logic [2:0] {IDLE, ARMED, IN_DROP, EVAL, DELAY, FIRE, HOLDOFF} fads_state_t;
endpackage

// File: rtl/red_pitaya_fads_ctrl_if.sv
// red_pitaya_fads_ctrl_if: ADC sample, housekeeping config and sort/measurement results.
interface red_pitaya_fads_ctrl_if #(
   parameter int DW = red_pitaya_fads_pkg::FADS_DW,
   parameter int WW = red_pitaya_fads_pkg::FADS_WW,
   parameter int TW = red_pitaya_fads_pkg::FADS_TW,
   parameter int CW = red_pitaya_fads_pkg::FADS_CW
);
   logic signed [DW-1:0] adc_a_i, cfg_det_thr_i, cfg_sort_thr_i, drop_peak_o;
   logic                 cfg_enable_i, cnt_clr_i, sort_trig_o, drop_valid_o, drop_sort_o, busy_o;
   logic [WW-1:0]        cfg_min_width_i, cfg_max_width_i, drop_width_o;
   logic [TW-1:0]        cfg_delay_i, cfg_pulse_len_i, cfg_holdoff_i;
   logic [CW-1:0]        cnt_drop_o, cnt_sort_o;
   modport master (
      output adc_a_i, cfg_enable_i, cfg_det_thr_i, cfg_sort_thr_i, cfg_min_width_i, cfg_max_width_i,
             cfg_delay_i, cfg_pulse_len_i, cfg_holdoff_i, cnt_clr_i,
      input  sort_trig_o, drop_valid_o, drop_width_o, drop_peak_o, drop_sort_o, cnt_drop_o, cnt_sort_o, busy_o
   );
   modport slave (
      input  adc_a_i, cfg_enable_i, cfg_det_thr_i, cfg_sort_thr_i, cfg_min_width_i, cfg_max_width_i,
             cfg_delay_i, cfg_pulse_len_i, cfg_holdoff_i, cnt_clr_i,
      output sort_trig_o, drop_valid_o, drop_width_o, drop_peak_o, drop_sort_o, cnt_drop_o, cnt_sort_o, busy_o
   );
endinterface

// File: rtl/red_pitaya_fads_meas.sv
// red_pitaya_fads_meas: droplet width counter (saturating) and signed peak tracker.
module red_pitaya_fads_meas
   import red_pitaya_fads_pkg::*;
#(
   parameter int DW = FADS_DW,
   parameter int WW = FADS_WW
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start,
   input  logic                 i_run,
   input  logic signed [DW-1:0] i_value,
   output logic [WW-1:0]        o_width,
   output logic signed [DW-1:0] o_peak
);
   logic [WW-1:0]        r_width;
   logic signed [DW-1:0] r_peak;
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_width <= '0;
         r_peak  <= '0;
      end else if (i_start) begin
         r_width <= WW'(1);
         r_peak  <= i_value;
      end else if (i_run) begin
         r_width <= (&r_width) ? r_width : r_width + WW'(1);
         r_peak  <= (i_value > r_peak) ? i_value : r_peak;
      end
   end
   assign o_width = r_width;
   assign o_peak  = r_peak;
endmodule

// File: rtl/red_pitaya_fads_ctrl.sv
// red_pitaya_fads_ctrl: FADS droplet qualifier and sort-pulse sequencer.
module red_pitaya_fads_ctrl
   import red_pitaya_fads_pkg::*;
#(
   parameter int DW = FADS_DW,
   parameter int WW = FADS_WW,
   parameter int TW = FADS_TW,
   parameter int CW = FADS_CW
) (
   input  logic                   adc_clk_i,
   input  logic                   adc_rst_i,
   red_pitaya_fads_ctrl_if.slave  bus
);
   fads_state_t          r_state;
   logic signed [DW-1:0] r_adc_q, r_peak;
   logic [WW-1:0]        r_width;
   logic [TW-1:0]        r_cnt, r_delay, r_pulse, r_hold;
   logic [CW-1:0]        r_cnt_drop, r_cnt_sort;
   logic                 r_trig, r_valid, r_sort, r_busy;
   logic                 w_above, w_sort;
   logic [WW-1:0]        w_width;
   logic signed [DW-1:0] w_peak;
   assign w_above = r_adc_q > bus.cfg_det_thr_i;
   assign w_sort  = (bus.cfg_min_width_i <= w_width) && (w_width <= bus.cfg_max_width_i) &&
                    (w_peak >= bus.cfg_sort_thr_i);
   red_pitaya_fads_meas #(.DW(DW), .WW(WW)) u_meas (
      .i_clk(adc_clk_i), .i_rst(adc_rst_i),
      .i_start(r_state == ARMED && w_above), .i_run(r_state == IN_DROP && w_above),
      .i_value(r_adc_q), .o_width(w_width), .o_peak(w_peak)
   );
   always_ff @(posedge adc_clk_i) begin
      if (adc_rst_i) begin
         r_state <= IDLE;
         r_adc_q <= '0;
         {r_cnt, r_delay, r_pulse, r_hold, r_cnt_drop, r_cnt_sort} <= '0;
         {r_trig, r_valid, r_sort, r_busy, r_width, r_peak} <= '0;
      end else begin
         r_adc_q <= bus.adc_a_i;
         r_valid <= 1'b0;
         if (r_state == EVAL) r_cnt_drop <= r_cnt_drop + CW'(1);
         if (!bus.cfg_enable_i) begin
            r_state <= IDLE;
            r_trig  <= 1'b0;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               IDLE: r_state <= ARMED;
               ARMED: if (w_above) begin
                  r_state <= IN_DROP;
                  r_busy  <= 1'b1;
               end
               IN_DROP: if (!w_above) begin
                  r_state <= EVAL;
                  r_valid <= 1'b1;
                  r_width <= w_width;
                  r_peak  <= w_peak;
                  r_sort  <= w_sort;
               end
               EVAL: begin
                  // timing config is frozen here for the rest of this droplet
                  r_delay <= bus.cfg_delay_i;
                  r_pulse <= (bus.cfg_pulse_len_i == '0) ? TW'(1) : bus.cfg_pulse_len_i;
                  r_hold  <= (bus.cfg_holdoff_i == '0) ? TW'(1) : bus.cfg_holdoff_i;
                  r_cnt   <= TW'(1);
                  r_state <= !r_sort ? HOLDOFF : (bus.cfg_delay_i == '0) ? FIRE : DELAY;
                  r_trig  <= r_sort && bus.cfg_delay_i == '0;
                  if (r_sort && bus.cfg_delay_i == '0) r_cnt_sort <= r_cnt_sort + CW'(1);
               end
               DELAY: if (r_cnt == r_delay) begin
                  r_state    <= FIRE;
                  r_trig     <= 1'b1;
                  r_cnt      <= TW'(1);
                  r_cnt_sort <= r_cnt_sort + CW'(1);
               end else r_cnt <= r_cnt + TW'(1);
               FIRE: if (r_cnt == r_pulse) begin
                  r_state <= HOLDOFF;
                  r_trig  <= 1'b0;
                  r_cnt   <= TW'(1);
               end else r_cnt <= r_cnt + TW'(1);
               HOLDOFF: if (r_cnt == r_hold) begin
                  r_state <= ARMED;
                  r_busy  <= 1'b0;
               end else r_cnt <= r_cnt + TW'(1);
               default: r_state <= IDLE;
            endcase
         end
         if (bus.cnt_clr_i) {r_cnt_drop, r_cnt_sort} <= '0;
      end
   end
   assign bus.sort_trig_o  = r_trig;
   assign bus.drop_valid_o = r_valid;
   assign bus.drop_width_o = r_width;
   assign bus.drop_peak_o  = r_peak;
   assign bus.drop_sort_o  = r_sort;
   assign bus.cnt_drop_o   = r_cnt_drop;
   assign bus.cnt_sort_o   = r_cnt_sort;
   assign bus.busy_o       = r_busy;
endmodule
